// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing one VRAM controller among NUM_PORTS byte requesters,
// with periodic forced refresh and a watchdog that aborts accesses the controller never completes.
module vram_port_arbiter #(
  parameter int NUM_PORTS       = 3,
  parameter int ADDR_WIDTH      = 23,
  parameter int REFRESH_CYCLES  = 1620,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS-1:0]            port_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*8-1:0]          port_wdata,
  output logic [NUM_PORTS-1:0]            port_ack,
  output logic [15:0]                     port_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic                            mem_refresh,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [7:0]                      mem_din8,
  input  logic                            mem_done,
  input  logic [15:0]                     mem_dout16,
  output logic                            busy,
  output logic [1:0]                      grant,
  output logic                            fail
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WATCHDOG_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] REFRESH = 2'd3;

  logic [1:0]            state_reg;
  logic [1:0]            last_reg;
  logic                  wr_reg;
  logic [RW-1:0]         ref_cnt_reg;
  logic                  refresh_due_reg;
  logic [WW-1:0]         wd_cnt_reg;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [7:0]            wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req_eff;
  logic                  win_found;
  logic [1:0]            win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = port_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = port_wdata[gi*8 +: 8];
    end
  endgenerate

  // The port just acked still holds its request during the ack cycle; hide it.
  assign req_eff = port_req & ~port_ack;
  assign busy    = (state_reg != IDLE);

  function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_PORTS;
    return s[1:0];
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!win_found && req_eff[rr_index(last_reg, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(last_reg, k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      last_reg        <= 2'(NUM_PORTS - 1);
      wr_reg          <= 1'b0;
      ref_cnt_reg     <= '0;
      refresh_due_reg <= 1'b0;
      wd_cnt_reg      <= '0;
      grant           <= 2'd0;
      port_ack        <= '0;
      port_rdata      <= 16'h0000;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_refresh     <= 1'b0;
      mem_addr        <= '0;
      mem_din8        <= 8'h00;
      fail            <= 1'b0;
    end else begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_refresh <= 1'b0;
      port_ack    <= '0;

      // Counter parks at its terminal value until the refresh is actually taken.
      if (state_reg == IDLE && refresh_due_reg) begin
        ref_cnt_reg     <= '0;
        refresh_due_reg <= 1'b0;
      end else if (!refresh_due_reg) begin
        if (ref_cnt_reg == REF_LAST) refresh_due_reg <= 1'b1;
        else                         ref_cnt_reg     <= ref_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (refresh_due_reg) begin
            state_reg   <= REFRESH;
            mem_refresh <= 1'b1;
          end else if (win_found) begin
            state_reg <= ISSUE;
            grant     <= win_idx;
            last_reg  <= win_idx;
            wr_reg    <= port_wr[win_idx];
            mem_addr  <= addr_arr[win_idx];
            mem_din8  <= wdata_arr[win_idx];
            mem_read  <= !port_wr[win_idx];
            mem_write <= port_wr[win_idx];
          end
        end
        ISSUE: begin
          state_reg  <= WAIT;
          wd_cnt_reg <= '0;
        end
        WAIT: begin
          if (mem_done) begin
            if (!wr_reg) port_rdata <= mem_dout16;
            port_ack[grant] <= 1'b1;
            state_reg       <= IDLE;
            wd_cnt_reg      <= '0;
          end else if (wd_cnt_reg == WD_LAST) begin
            fail            <= 1'b1;
            port_rdata      <= 16'hFFFF;
            port_ack[grant] <= 1'b1;
            state_reg       <= IDLE;
            wd_cnt_reg      <= '0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        REFRESH: begin
          if (mem_done) begin
            state_reg  <= IDLE;
            wd_cnt_reg <= '0;
          end else if (wd_cnt_reg == WD_LAST) begin
            fail       <= 1'b1;
            state_reg  <= IDLE;
            wd_cnt_reg <= '0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: a small controller model answers commands
// after a programmable latency; checks cover latency, round-robin, refresh, watchdog and reset.
module tb_vram_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 23;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NP-1:0]   port_req, port_wr, port_ack;
  logic [NP*AW-1:0] port_addr;
  logic [NP*8-1:0] port_wdata;
  logic [15:0]     port_rdata, mem_dout16;
  logic            mem_read, mem_write, mem_refresh, mem_done, busy, fail;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_din8;
  logic [1:0]      grant;

  int checks = 0, failures = 0;
  int lat = 1, ref_lat = 2, cnt = 0;
  bit respond_en = 1'b1;
  logic [15:0] dout_val = 16'h0000;
  int n_rw = 0, n_ref = 0, n_ack = 0;
  int ev[$];

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .REFRESH_CYCLES(1620), .WATCHDOG_CYCLES(255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port_req(port_req), .port_wr(port_wr),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_ack(port_ack),
    .port_rdata(port_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_refresh(mem_refresh), .mem_addr(mem_addr), .mem_din8(mem_din8),
    .mem_done(mem_done), .mem_dout16(mem_dout16), .busy(busy), .grant(grant), .fail(fail)
  );

  // Controller model: mem_done lands 'lat' cycles after the command cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      cnt        = 0;
      mem_done   = 1'b0;
      mem_dout16 = 16'h0000;
    end else begin
      mem_done   = 1'b0;
      mem_dout16 = 16'h0000;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_done   = 1'b1;
          mem_dout16 = dout_val;
        end
      end
      if (mem_read || mem_write) begin
        n_rw++;
        if (respond_en) cnt = lat;
      end
      if (mem_refresh) begin
        n_ref++;
        ev.push_back(9);
        cnt = ref_lat;
        $display("txn refresh");
      end
      for (int i = 0; i < NP; i++) begin
        if (port_ack[i]) begin
          n_ack++;
          ev.push_back(i);
          $display("txn ack port=%0d rdata=%h fail=%0b", i, port_rdata, fail);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (port_ack == '0 && cyc < budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    port_req = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic int ack_index(input logic [NP-1:0] a);
    for (int i = 0; i < NP; i++) if (a[i]) return i;
    return -1;
  endfunction

  int c, base;
  int exp_ev[3] = '{2, 9, 0};

  initial begin
    port_req = '0; port_wr = '0; port_addr = '0; port_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_fail", fail, 0);
    check("rst_grant", grant, 0);
    check("rst_ack", port_ack, 0);
    check("rst_rdata", port_rdata, 0);
    check("rst_cmd", {mem_read, mem_write, mem_refresh}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Port 1 read, controller latency 3
    base = n_rw;
    port_addr[1*AW +: AW] = 23'h000123;
    dout_val = 16'hBEEF; lat = 3; port_req = 3'b010;
    @(negedge clk);
    check("t1_rd_pulse", mem_read, 1);
    check("t1_wr_pulse", mem_write, 0);
    check("t1_addr", mem_addr, 23'h000123);
    check("t1_grant", grant, 1);
    check("t1_busy", busy, 1);
    wait_ack(20, c);
    check("t1_latency", c, 4);
    check("t1_ack", port_ack, 3'b010);
    check("t1_rdata", port_rdata, 16'hBEEF);
    port_req = '0;
    repeat (3) @(negedge clk);
    check("t1_one_read", n_rw - base, 1);
    check("t1_idle", busy, 0);

    // All ports request continuously from reset
    do_reset();
    lat = 1; port_wr = '0; port_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(20, c);
      check($sformatf("t2_grant%0d", k), ack_index(port_ack), k % 3);
    end
    port_req = '0;
    repeat (3) @(negedge clk);

    // Refresh becomes due while port 2 waits
    do_reset();
    lat = 10; ref_lat = 2; port_wr = '0;
    port_addr[2*AW +: AW] = 23'h400000; dout_val = 16'hC0DE;
    repeat (1612) @(negedge clk);
    ev.delete();
    base = n_ref;
    port_req = 3'b100;
    wait_ack(40, c);
    check("t3_p2_ack", port_ack, 3'b100);
    check("t3_p2_rdata", port_rdata, 16'hC0DE);
    check("t3_no_ref_yet", n_ref - base, 0);
    check("t3_due_pending", dut.refresh_due_reg, 1);
    port_req = 3'b001; lat = 2;
    port_addr[0 +: AW] = 23'h000010;
    wait_ack(40, c);
    check("t3_p0_ack", port_ack, 3'b001);
    port_req = '0;
    repeat (2) @(negedge clk);
    check("t3_ev_len", ev.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_ev%0d", i), (i < ev.size()) ? ev[i] : -1, exp_ev[i]);
    check("t3_due_clr", dut.refresh_due_reg, 0);
    check("t3_one_ref", n_ref - base, 1);

    // Write 0x5A that the controller never completes
    respond_en = 1'b0;
    port_wr = 3'b001; port_addr[0 +: AW] = 23'h7FFFFF; port_wdata[0 +: 8] = 8'h5A;
    port_req = 3'b001;
    @(negedge clk);
    check("t4_wr_pulse", mem_write, 1);
    check("t4_rd_pulse", mem_read, 0);
    check("t4_din", mem_din8, 8'h5A);
    check("t4_addr", mem_addr, 23'h7FFFFF);
    repeat (254) @(negedge clk);
    check("t4_fail_early", fail, 0);
    check("t4_ack_early", port_ack, 0);
    wait_ack(10, c);
    check("t4_abort_time", c, 2);
    check("t4_ack", port_ack, 3'b001);
    check("t4_rdata", port_rdata, 16'hFFFF);
    check("t4_fail", fail, 1);
    port_req = '0; port_wr = '0; respond_en = 1'b1;
    lat = 2; dout_val = 16'h1234; port_addr[1*AW +: AW] = 23'h000002;
    @(negedge clk);
    port_req = 3'b010;
    wait_ack(20, c);
    check("t4_next_ack", port_ack, 3'b010);
    check("t4_next_rdata", port_rdata, 16'h1234);
    check("t4_fail_sticky", fail, 1);
    port_req = '0;
    @(negedge clk);

    // Reset in the middle of a WAIT
    lat = 50; dout_val = 16'h5555; port_req = 3'b010;
    repeat (5) @(negedge clk);
    check("t5_busy_wait", busy, 1);
    reset_n = 1'b0; port_req = '0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_grant", grant, 0);
    check("t5_ack", port_ack, 0);
    check("t5_rdata", port_rdata, 0);
    check("t5_fail", fail, 0);
    check("t5_cmd", {mem_read, mem_write, mem_refresh}, 0);
    check("t5_addr", mem_addr, 0);
    base = n_ack;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_no_ack", n_ack - base, 0);
    lat = 1; port_req = 3'b111;
    wait_ack(20, c);
    check("t5_first_grant", ack_index(port_ack), 0);
    port_req = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, meaning the number of requester ports (legal range 2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 23, meaning the VRAM byte-address width.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 1620, meaning the clk cycles between forced refreshes (15 us at 108 MHz).
REQ-004 SHALL have parameter WATCHDOG_CYCLES, default 255, meaning the maximum wait for mem_done before abort.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port port_req, input, NUM_PORTS bits: level request per port, held until that port's ack.
REQ-008 SHALL have port port_wr, input, NUM_PORTS bits: 1 = write, 0 = read.
REQ-009 SHALL have port port_addr, input, NUM_PORTS*ADDR_WIDTH bits: port i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port port_wdata, input, NUM_PORTS*8 bits: write byte, port i occupies [i*8 +: 8].
REQ-011 SHALL have port port_ack, output, NUM_PORTS bits: one-cycle completion pulse per port.
REQ-012 SHALL have port port_rdata, output, 16 bits: read data shared by all ports, valid in the port_ack cycle and held until the next read completes.
REQ-013 SHALL have ports mem_read, mem_write and mem_refresh, output, 1 bit each: one-cycle command pulses to the memory controller.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH bits, and port mem_din8, output, 8 bits: command address and write data, stable from the command pulse until mem_done.
REQ-015 SHALL have port mem_done, input, 1 bit: controller completion pulse, with mem_dout16 (input, 16 bits) valid in the same cycle for reads.
REQ-016 SHALL have ports busy (output, 1 bit), grant (output, 2 bits: index of the active port) and fail (output, 1 bit: sticky watchdog error).

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and REFRESH.
REQ-018 IDLE SHALL go to REFRESH when refresh_due is set; otherwise, on any port_req, it SHALL latch the winner's wr, addr and wdata, set grant, and go to ISSUE.
REQ-019 The winner SHALL be chosen by round-robin, searching upward from (last granted port + 1) mod NUM_PORTS; after reset, last granted = NUM_PORTS-1.
REQ-020 ISSUE SHALL assert exactly one of mem_read or mem_write for exactly one cycle and then go to WAIT.
REQ-021 WAIT on mem_done: reads SHALL capture mem_dout16 into port_rdata; port_ack[grant] SHALL pulse the next cycle; the state SHALL return to IDLE in that same ack cycle.
REQ-022 A requester's minimum latency SHALL be port_req sampled at edge N -> command pulse during cycle N+1 -> port_ack one cycle after mem_done.
REQ-023 A refresh counter SHALL increment every cycle while refresh_due is clear, SHALL set refresh_due on reaching REFRESH_CYCLES-1, and SHALL clear both when REFRESH is entered.
REQ-024 REFRESH SHALL pulse mem_refresh for one cycle, wait for mem_done, then return to IDLE; refresh SHALL have priority over every port but never preempts an access in flight.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Simultaneous events: if mem_done and a new port_req occur in the same cycle, the new request SHALL be arbitrated in the following IDLE cycle; requests of the acked port SHALL be ignored until its ack cycle has passed.
REQ-027 If port_req drops before ack, the access SHALL still complete and ack SHALL still pulse.
REQ-028 A watchdog SHALL count cycles in WAIT and REFRESH; on reaching WATCHDOG_CYCLES it SHALL set fail, pulse port_ack[grant] with port_rdata = 16'hFFFF (no ack for a refresh), and return to IDLE.
REQ-029 The refresh and watchdog counters SHALL be sized with $clog2 and SHALL never wrap past their terminal value.

Reset
REQ-030 While reset_n = 0: state = IDLE; all command pulses, port_ack, busy, fail and the counters = 0; port_rdata = 0; grant = 0.
REQ-031 Reset asserted mid-access SHALL abandon the access without an ack; after release, the first refresh is due REFRESH_CYCLES cycles later.

Verification
REQ-032 Port 1 read at addr 0x000123; the controller returns mem_done with 0xBEEF three cycles after mem_read -> exactly one mem_read pulse with mem_addr = 0x000123; port_ack = 3'b010 with port_rdata = 0xBEEF one cycle after mem_done.
REQ-033 All three ports request continuously -> grants follow the order 0, 1, 2, 0, 1, 2; no port acked twice in a row.
REQ-034 Refresh becomes due while port 2 is in WAIT -> port 2 completes first; mem_refresh is then pulsed before any further grant; refresh_due is cleared.
REQ-035 mem_done is never returned for a write of 0x5A -> fail = 1 after 255 WAIT cycles; port_ack pulses with rdata 0xFFFF; the next request is still served.
REQ-036 reset_n is pulsed low during WAIT -> no port_ack; all outputs read 0; normal arbitration resumes from port 0.
